// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and legality check for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMW   = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  // Legal funct3 for the direction and naturally aligned for its size
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] addr);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr[0];
      F3_W:    ok = (addr == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] mem_rd,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data_c,
  output logic [XLEN-1:0] st_word_c
);

  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [XLEN-1:0] rd_shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] lane_data;

  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[1], 4'b0000};

  // Select the addressed byte/half and extend it to a full word
  always_comb begin
    rd_shifted = mem_rd >> byte_sh;
    ld_byte    = rd_shifted[7:0];
    ld_half    = addr_lo[1] ? mem_rd[XLEN-1:16] : mem_rd[15:0];
    ld_data_c  = '0;
    case (f3)
      F3_B:    ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_W:    ld_data_c = mem_rd;
      F3_BU:   ld_data_c = XLEN'(ld_byte);
      F3_HU:   ld_data_c = XLEN'(ld_half);
      default: ld_data_c = '0;
    endcase
  end

  // Overlay the low byte/half of the store data onto the current memory word
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (f3)
      F3_B: begin
        lane_mask = XLEN'(32'h0000_00FF) << byte_sh;
        lane_data = XLEN'(wdata[7:0]) << byte_sh;
      end
      F3_H: begin
        lane_mask = XLEN'(32'h0000_FFFF) << half_sh;
        lane_data = XLEN'(wdata[15:0]) << half_sh;
      end
      F3_W: begin
        lane_mask = '1;
        lane_data = wdata;
      end
      default: begin
        lane_mask = '0;
        lane_data = '0;
      end
    endcase
    st_word_c = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-wide memory, RMW for SB/SH.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] wbuf_q, wbuf_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ld_data_c;
  logic [XLEN-1:0] st_word_c;

  lsu_align u_align (
    .mem_rd    (mem_rd),
    .addr_lo   (addr_q[1:0]),
    .f3        (f3_q),
    .wdata     (wdata_q),
    .ld_data_c (ld_data_c),
    .st_word_c (st_word_c)
  );

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (!is_legal(req_we, req_funct3, req_addr[1:0])) begin
            state_d = ERR;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == F3_W) begin
            wbuf_d  = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = RMW;
          end
        end
      end
      LOAD: begin
        rdata_d = ld_data_c;
        state_d = RESP;
      end
      RMW: begin
        wbuf_d  = st_word_c;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wd     = wbuf_q;
  // A reset arriving during WRITE must not let the write land
  assign mem_we     = (state_q == WRITE) & ~rst;

endmodule
